// File: rtl/pong_pkg.sv
// Shared definitions for the LED-matrix bounce game: match states and field geometry.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_POINT = 3'd4,
    ST_OVER  = 3'd5
  } pong_state_e;

  localparam logic [3:0] UP_MOST   = 4'd0;
  localparam logic [3:0] DOWN_MOST = 4'd15;
  localparam logic [3:0] BAR1_Y    = 4'd12;
  localparam logic [3:0] BAR2_Y    = 4'd3;

  function automatic logic [13:0] score_to_disp(input logic [3:0] s1, input logic [3:0] s2);
    return (14'(s1) * 14'd100) + 14'(s2);
  endfunction

endpackage

// File: rtl/pong_game_ctrl_rise_detect.sv
// One-bit rising-edge detector for the start button level.
module rise_detect (
  input  logic CLK,
  input  logic RSTn,
  input  logic din,
  output logic rise
);

  logic prev;
  logic primed;

  // Keep last cycle's sample; primed stays low for the first cycle after reset so a
  // button already held down while reset releases is not mistaken for a fresh press.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      prev   <= 1'b0;
      primed <= 1'b0;
    end else begin
      prev   <= din;
      primed <= 1'b1;
    end
  end

  assign rise = primed & din & ~prev;

endmodule

// File: rtl/pong_game_ctrl.sv
// Match-flow controller: serve, rally, point, pause and game over, plus score keeping.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter logic [3:0] WIN_SCORE   = 4'd5,
  parameter logic [7:0] SERVE_TICKS = 8'd16,
  parameter logic [7:0] POINT_TICKS = 8'd32
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        tick,
  input  logic        start,
  input  logic [3:0]  ball_y,
  output logic        ball_run,
  output logic        ball_load,
  output logic        serve_side,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic        blink,
  output logic [13:0] disp_value,
  output logic [2:0]  state
);

  pong_state_e st;
  logic [7:0]  tick_cnt;
  logic [7:0]  tick_cnt_inc;
  logic        start_rise;
  logic        miss1;
  logic        miss2;

  assign tick_cnt_inc = tick_cnt + 8'd1;
  assign miss1        = (ball_y == DOWN_MOST);
  assign miss2        = (ball_y == UP_MOST);
  assign state        = st;

  rise_detect u_start_rise (
    .CLK  (CLK),
    .RSTn (RSTn),
    .din  (start),
    .rise (start_rise)
  );

  // Match sequencer; every output is a register updated together with the state,
  // and the tick counter is left alone across PLAY/PAUSE since neither uses it.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      st         <= ST_IDLE;
      tick_cnt   <= 8'd0;
      ball_run   <= 1'b0;
      ball_load  <= 1'b0;
      serve_side <= 1'b0;
      score1     <= 4'd0;
      score2     <= 4'd0;
      blink      <= 1'b0;
    end else begin
      ball_load <= 1'b0;
      case (st)
        ST_IDLE: begin
          ball_run <= 1'b0;
          blink    <= 1'b0;
          if (start_rise) begin
            st         <= ST_SERVE;
            tick_cnt   <= 8'd0;
            score1     <= 4'd0;
            score2     <= 4'd0;
            serve_side <= 1'b0;
            ball_load  <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (tick) begin
            if (tick_cnt_inc == SERVE_TICKS) begin
              st       <= ST_PLAY;
              tick_cnt <= 8'd0;
              ball_run <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt_inc;
            end
          end
        end
        ST_PLAY: begin
          if (miss1) begin
            if (score2 < WIN_SCORE) score2 <= score2 + 4'd1;
            serve_side <= 1'b0;
            st         <= ST_POINT;
            tick_cnt   <= 8'd0;
            ball_run   <= 1'b0;
          end else if (miss2) begin
            if (score1 < WIN_SCORE) score1 <= score1 + 4'd1;
            serve_side <= 1'b1;
            st         <= ST_POINT;
            tick_cnt   <= 8'd0;
            ball_run   <= 1'b0;
          end else if (start_rise) begin
            st       <= ST_PAUSE;
            ball_run <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (start_rise) begin
            st       <= ST_PLAY;
            ball_run <= 1'b1;
          end
        end
        ST_POINT: begin
          if (tick) begin
            blink <= ~blink;
            if (tick_cnt_inc == POINT_TICKS) begin
              tick_cnt <= 8'd0;
              if ((score1 == WIN_SCORE) || (score2 == WIN_SCORE)) begin
                st <= ST_OVER;
              end else begin
                st        <= ST_SERVE;
                ball_load <= 1'b1;
                blink     <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt_inc;
            end
          end
        end
        ST_OVER: begin
          if (start_rise) begin
            st         <= ST_SERVE;
            tick_cnt   <= 8'd0;
            score1     <= 4'd0;
            score2     <= 4'd0;
            serve_side <= 1'b0;
            ball_load  <= 1'b1;
            blink      <= 1'b0;
          end else if (tick) begin
            blink <= ~blink;
          end
        end
        default: begin
          st       <= ST_IDLE;
          tick_cnt <= 8'd0;
          ball_run <= 1'b0;
          blink    <= 1'b0;
        end
      endcase
    end
  end

  // Display value is rebuilt from the registered scores, so it trails a score change by one cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      disp_value <= 14'd0;
    end else begin
      disp_value <= score_to_disp(score1, score2);
    end
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-sequencing controller for the 8x16 LED-matrix bounce game. It owns the match flow: idle, serve, rally, point, pause and game over. It gates ball motion, requests ball re-placement at the serving bar, keeps both players' scores, and produces the value shown by the 4-digit 7-segment driver. It sits between the ball/bar datapath (ball position in, motion enable and load out) and the `BIN14to7SEG4` display driver.

## Interface
- `WIN_SCORE`, 4'd5: points needed to win; range 1..9.
- `SERVE_TICKS`, 8'd16: `tick` strobes spent in SERVE before the ball is released.
- `POINT_TICKS`, 8'd32: `tick` strobes spent in POINT (blink phase).
- `CLK` in 1: system clock.
- `RSTn` in 1: reset, asynchronous, active-low; clock `CLK`.
- `tick` in 1: one-cycle ball-step strobe from the ball prescaler; consecutive strobes are at least 4 cycles apart.
- `start` in 1: synchronized button level (press = 1); debounce is done upstream.
- `ball_y` in 4: current ball row, 0 = top (bar2 side), 15 = bottom (bar1 side).
- `ball_run` out 1: ball may move on `tick`.
- `ball_load` out 1: one-cycle pulse; ball datapath re-places the ball on the serving bar.
- `serve_side` out 1: 0 = bar1 serves, 1 = bar2 serves.
- `score1` out 4: bar1 player score.
- `score2` out 4: bar2 player score.
- `blink` out 1: display blink phase; the LED driver blanks the ball when it is 1.
- `disp_value` out 14: `score1*100 + score2`, feeds the 7-seg driver.
- `state` out 3: current state, for debug.

## Operation
- Start press is detected as a rising edge: the previous-cycle sample is 0 and the current sample is 1. The sample register resets to 0.
- IDLE:
  - `ball_run`=0, `blink`=0.
  - Start edge → SERVE. Scores clear to 0, `serve_side`=0, `ball_load` pulses.
- SERVE:
  - Counts `tick` strobes from 0.
  - When the count reaches `SERVE_TICKS` → PLAY.
  - Start edges are ignored.
- PLAY:
  - `ball_run`=1.
  - `ball_y`==15 means bar1 missed: `score2`++ and `serve_side`←0.
  - `ball_y`==0 means bar2 missed: `score1`++ and `serve_side`←1.
  - Either miss → POINT.
  - Start edge with no miss → PAUSE. If a miss and a start edge occur in the same cycle, the miss wins.
- PAUSE: `ball_run`=0; start edge → PLAY. The tick counter is untouched.
- POINT:
  - `ball_run`=0.
  - `blink` toggles on every `tick`.
  - After `POINT_TICKS` ticks: if either score equals `WIN_SCORE` → OVER. Otherwise → SERVE with a `ball_load` pulse.
- OVER:
  - `blink` keeps toggling on `tick`.
  - Scores are held.
  - Start edge → SERVE with scores cleared, `serve_side`=0, `ball_load` pulse.
- Scores saturate at `WIN_SCORE` and never wrap.
- `disp_value` is recomputed from the registered scores; max 909 fits in 14 bits.
- Tick counter: 8 bits, cleared on every state entry, and incremented only on `tick`.
- Unused `state` encodings → IDLE on the next clock.

## Timing
- Reset values: state IDLE, `ball_run` 0, `ball_load` 0, `serve_side` 0, `score1`/`score2` 0, `blink` 0, `disp_value` 0.
- All outputs are registered. A state change and its output change appear together, 1 cycle after the causing input cycle.
- Miss detected in cycle N:
  - `ball_run` falls and the score updates at edge N+1.
  - `disp_value` updates at N+2, one extra register stage.
- Start edge in cycle N: state changes at N+1.
- `ball_load` is high for exactly the first cycle of SERVE.
- SERVE leaves on the edge after the `SERVE_TICKS`-th tick. POINT leaves on the edge after the `POINT_TICKS`-th tick.
- `blink` is cleared on entry to SERVE and IDLE.
- Reset asserted mid-rally forces all reset values immediately; operation resumes in IDLE.

## Structure
- Shared package `pong_pkg` holds:
  - state encodings `ST_IDLE`, `ST_SERVE`, `ST_PLAY`, `ST_PAUSE`, `ST_POINT`, `ST_OVER`;
  - field constants `UP_MOST`=0, `DOWN_MOST`=15, `BAR1_Y`=12, `BAR2_Y`=3.
- The ball and LED modules reuse the same package.
- One sub-module, `rise_detect`: 1-bit registered rising-edge detector used for `start`.

## Test plan
- Reset, start pulse → `ball_load`=1 for one cycle, state SERVE; after 16 ticks `ball_run`=1.
- In PLAY, drive `ball_y`=15 → next cycle `score2`=1, `ball_run`=0, `serve_side`=0; after 32 ticks back to SERVE with `ball_load` pulse.
- In PLAY, drive `ball_y`=0 five times → `score1`=5, `disp_value`=500, state OVER, `blink` toggling; start edge → scores 0, SERVE.
- In PLAY, start edge → PAUSE with `ball_run`=0; second start edge → PLAY; `ball_y`=0 during PAUSE leaves scores unchanged.
- Same cycle start edge and `ball_y`=15 in PLAY → POINT with `score2`+1, no PAUSE entry.
- Assert `RSTn`=0 during POINT → all outputs at reset values immediately; start held high through reset release produces no edge.
